// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared game state, collision and direction encodings
package snake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PLAY  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } game_state_t;

   localparam logic [1:0] NO_COLLISION    = 2'b00;
   localparam logic [1:0] APPLE_COLLISION = 2'b01;
   localparam logic [1:0] WALL_COLLISION  = 2'b10;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   localparam logic [9:0] SCORE_MAX = 10'd1023;

   // Swaps up<->down and left<->right.
   function automatic logic [3:0] opposite_dir(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

endpackage

// File: rtl/dir_filter.sv
// rtl/dir_filter.sv - accepts a direction request only if one-hot and not a reversal
module dir_filter
   import snake_pkg::*;
(
   input  logic [3:0] dir_in,
   input  logic [3:0] dir_cur,
   output logic       dir_ok
);

   logic one_hot;

   always_comb begin
      one_hot = (dir_in != 4'b0000) && ((dir_in & (dir_in - 4'd1)) == 4'b0000);
      dir_ok  = one_hot && (dir_in != opposite_dir(dir_cur));
   end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - snake game FSM: step gating, direction commit, per-frame scoring
module game_sequencer
   import snake_pkg::*;
#(
   parameter logic [7:0] INIT_LEN = 8'd1,
   parameter logic [7:0] MAX_LEN  = 8'd64
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       move_tick,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic [1:0] collision,
   input  logic [3:0] dir_in,
   output logic [1:0] state,
   output logic       game_over,
   output logic       move_en,
   output logic [3:0] dir_out,
   output logic [7:0] snake_length,
   output logic       apple_refresh,
   output logic [9:0] score
);

   game_state_t state_q;
   logic        game_over_q;
   logic        move_en_q;
   logic        apple_refresh_q;
   logic [3:0]  dir_out_q;
   logic [3:0]  dir_req_q;
   logic [7:0]  len_q;
   logic [9:0]  score_q;
   logic        wall_pend_q;
   logic        apple_pend_q;

   logic        wall_now;
   logic        apple_now;
   logic        wall_eff;
   logic        apple_eff;
   logic        dir_ok;

   dir_filter u_dir_filter (
      .dir_in  (dir_in),
      .dir_cur (dir_out_q),
      .dir_ok  (dir_ok)
   );

   // Code 2'b11 is folded into wall; the commit sees this cycle's code as well.
   always_comb begin
      wall_now  = collision[1];
      apple_now = (collision == APPLE_COLLISION);
      wall_eff  = wall_pend_q | wall_now;
      apple_eff = apple_pend_q | apple_now;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         game_over_q     <= 1'b0;
         move_en_q       <= 1'b0;
         apple_refresh_q <= 1'b0;
         dir_out_q       <= DIR_RIGHT;
         dir_req_q       <= DIR_RIGHT;
         len_q           <= INIT_LEN;
         score_q         <= 10'd0;
         wall_pend_q     <= 1'b0;
         apple_pend_q    <= 1'b0;
      end else begin
         move_en_q       <= move_tick && (state_q == ST_PLAY);
         apple_refresh_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_btn) begin
                  state_q   <= ST_PLAY;
                  len_q     <= INIT_LEN;
                  score_q   <= 10'd0;
                  dir_out_q <= DIR_RIGHT;
                  dir_req_q <= DIR_RIGHT;
               end
            end
            ST_PLAY: begin
               if (move_tick)
                  dir_out_q <= dir_req_q;
               if (dir_ok)
                  dir_req_q <= dir_in;
               if (frame_start) begin
                  wall_pend_q  <= 1'b0;
                  apple_pend_q <= 1'b0;
                  if (wall_eff) begin
                     state_q     <= ST_OVER;
                     game_over_q <= 1'b1;
                  end else if (apple_eff) begin
                     len_q           <= (len_q < MAX_LEN) ? len_q + 8'd1 : len_q;
                     score_q         <= (score_q != SCORE_MAX) ? score_q + 10'd1 : score_q;
                     apple_refresh_q <= 1'b1;
                  end
               end else begin
                  wall_pend_q  <= wall_eff;
                  apple_pend_q <= apple_eff;
               end
               // A committed wall outranks a simultaneous pause.
               if (pause_btn && !(frame_start && wall_eff)) begin
                  state_q      <= ST_PAUSE;
                  wall_pend_q  <= 1'b0;
                  apple_pend_q <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (pause_btn || start_btn)
                  state_q <= ST_PLAY;
            end
            ST_OVER: begin
               if (start_btn) begin
                  state_q     <= ST_IDLE;
                  game_over_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign state         = state_q;
   assign game_over     = game_over_q;
   assign move_en       = move_en_q;
   assign dir_out       = dir_out_q;
   assign snake_length  = len_q;
   assign apple_refresh = apple_refresh_q;
   assign score         = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

   logic       vga_clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic       move_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       pause_btn = 1'b0;
   logic [1:0] collision = 2'b00;
   logic [3:0] dir_in = 4'b0000;

   logic [1:0] state, s_state;
   logic       game_over, s_game_over;
   logic       move_en, s_move_en;
   logic [3:0] dir_out, s_dir_out;
   logic [7:0] snake_length, s_snake_length;
   logic       apple_refresh, s_apple_refresh;
   logic [9:0] score, s_score;

   int checks = 0;
   int failures = 0;

   always #5 vga_clk = ~vga_clk;

   game_sequencer dut (
      .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start), .move_tick(move_tick),
      .start_btn(start_btn), .pause_btn(pause_btn), .collision(collision), .dir_in(dir_in),
      .state(state), .game_over(game_over), .move_en(move_en), .dir_out(dir_out),
      .snake_length(snake_length), .apple_refresh(apple_refresh), .score(score)
   );

   game_sequencer #(.INIT_LEN(8'd1), .MAX_LEN(8'd3)) dut_sat (
      .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start), .move_tick(move_tick),
      .start_btn(start_btn), .pause_btn(pause_btn), .collision(collision), .dir_in(dir_in),
      .state(s_state), .game_over(s_game_over), .move_en(s_move_en), .dir_out(s_dir_out),
      .snake_length(s_snake_length), .apple_refresh(s_apple_refresh), .score(s_score)
   );

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic press_start();
      start_btn = 1'b1; tick(); start_btn = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0h exp=0", state); end
      checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%0h exp=0", game_over); end
      checks++; if (move_en !== 1'b0 || apple_refresh !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%0h%0h exp=00", move_en, apple_refresh); end
      checks++; if (snake_length !== 8'd1 || score !== 10'd0) begin failures++; $display("FAIL reset_len_score got=%0d/%0d exp=1/0", snake_length, score); end
      checks++; if (dir_out !== 4'b1000) begin failures++; $display("FAIL reset_dir got=%b exp=1000", dir_out); end
   endtask

   task automatic test_start();
      press_start();
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL start_state got=%0h exp=1", state); end
      checks++; if (move_en !== 1'b0) begin failures++; $display("FAIL start_no_move got=%0h exp=0", move_en); end
      move_tick = 1'b1; tick(); move_tick = 1'b0;
      checks++; if (move_en !== 1'b1) begin failures++; $display("FAIL start_move_en got=%0h exp=1", move_en); end
      tick();
      checks++; if (move_en !== 1'b0) begin failures++; $display("FAIL start_move_en_width got=%0h exp=0", move_en); end
      checks++; if (dir_out !== 4'b1000) begin failures++; $display("FAIL start_dir got=%b exp=1000", dir_out); end
      checks++; if (snake_length !== 8'd1 || score !== 10'd0) begin failures++; $display("FAIL start_len_score got=%0d/%0d exp=1/0", snake_length, score); end
   endtask

   task automatic test_apple();
      int pulses = 0;
      collision = 2'b01;
      repeat (500) begin tick(); if (apple_refresh) pulses++; end
      collision = 2'b00;
      checks++; if (pulses != 0 || score !== 10'd0) begin failures++; $display("FAIL apple_precommit got=%0d/%0d exp=0/0", pulses, score); end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++; if (apple_refresh !== 1'b1) begin failures++; $display("FAIL apple_refresh got=%0h exp=1", apple_refresh); end
      checks++; if (snake_length !== 8'd2 || score !== 10'd1) begin failures++; $display("FAIL apple_len_score got=%0d/%0d exp=2/1", snake_length, score); end
      tick();
      checks++; if (apple_refresh !== 1'b0) begin failures++; $display("FAIL apple_refresh_width got=%0h exp=0", apple_refresh); end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++; if (apple_refresh !== 1'b0 || score !== 10'd1) begin failures++; $display("FAIL apple_cleared got=%0h/%0d exp=0/1", apple_refresh, score); end
   endtask

   task automatic test_wall_priority();
      collision = 2'b10; tick(); collision = 2'b01; tick(); collision = 2'b00;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++; if (state !== 2'b11 || game_over !== 1'b1) begin failures++; $display("FAIL wall_over got=%0h/%0h exp=3/1", state, game_over); end
      checks++; if (snake_length !== 8'd2 || score !== 10'd1 || apple_refresh !== 1'b0) begin failures++; $display("FAIL wall_no_apple got=%0d/%0d/%0h exp=2/1/0", snake_length, score, apple_refresh); end
   endtask

   task automatic test_over_buttons();
      pause_btn = 1'b1; tick(); pause_btn = 1'b0;
      checks++; if (state !== 2'b11) begin failures++; $display("FAIL over_pause_ignored got=%0h exp=3", state); end
      press_start();
      checks++; if (state !== 2'b00 || game_over !== 1'b0) begin failures++; $display("FAIL over_to_idle got=%0h/%0h exp=0/0", state, game_over); end
      start_btn = 1'b1; pause_btn = 1'b1; tick(); start_btn = 1'b0; pause_btn = 1'b0;
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL idle_start_pause got=%0h exp=1", state); end
      checks++; if (snake_length !== 8'd1 || score !== 10'd0 || dir_out !== 4'b1000) begin failures++; $display("FAIL new_game_init got=%0d/%0d/%b exp=1/0/1000", snake_length, score, dir_out); end
   endtask

   task automatic test_dir_filter();
      dir_in = 4'b0100; tick(); dir_in = 4'b0011; tick(); dir_in = 4'b0000;
      move_tick = 1'b1; tick(); move_tick = 1'b0;
      checks++; if (move_en !== 1'b1 || dir_out !== 4'b1000) begin failures++; $display("FAIL dir_reject got=%0h/%b exp=1/1000", move_en, dir_out); end
      dir_in = 4'b0001; tick(); dir_in = 4'b0000; tick();
      checks++; if (dir_out !== 4'b1000) begin failures++; $display("FAIL dir_hold_until_step got=%b exp=1000", dir_out); end
      move_tick = 1'b1; tick(); move_tick = 1'b0;
      checks++; if (dir_out !== 4'b0001) begin failures++; $display("FAIL dir_accept got=%b exp=0001", dir_out); end
   endtask

   task automatic test_pause();
      int moves = 0;
      pause_btn = 1'b1; tick(); pause_btn = 1'b0;
      checks++; if (state !== 2'b10) begin failures++; $display("FAIL pause_enter got=%0h exp=2", state); end
      collision = 2'b01; move_tick = 1'b1; tick(); if (move_en) moves++;
      move_tick = 1'b0; tick(); if (move_en) moves++;
      collision = 2'b00;
      pause_btn = 1'b1; tick(); pause_btn = 1'b0; if (move_en) moves++;
      tick(); if (move_en) moves++;
      checks++; if (moves != 0) begin failures++; $display("FAIL pause_move_dropped got=%0d exp=0", moves); end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++; if (apple_refresh !== 1'b0 || score !== 10'd0) begin failures++; $display("FAIL pause_apple_dropped got=%0h/%0d exp=0/0", apple_refresh, score); end
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL pause_resume got=%0h exp=1", state); end
   endtask

   task automatic test_back_to_back();
      collision = 2'b01; tick(); collision = 2'b00;
      frame_start = 1'b1; move_tick = 1'b1; tick(); frame_start = 1'b0; move_tick = 1'b0;
      checks++; if (move_en !== 1'b1 || apple_refresh !== 1'b1 || score !== 10'd1) begin failures++; $display("FAIL coincide got=%0h/%0h/%0d exp=1/1/1", move_en, apple_refresh, score); end
      collision = 2'b11; tick(); collision = 2'b00;
      frame_start = 1'b1; pause_btn = 1'b1; tick(); frame_start = 1'b0; pause_btn = 1'b0;
      checks++; if (state !== 2'b11 || score !== 10'd1) begin failures++; $display("FAIL pause_vs_wall got=%0h/%0d exp=3/1", state, score); end
   endtask

   task automatic test_saturation();
      reset = 1'b1; tick(); reset = 1'b0;
      press_start();
      repeat (3) begin
         collision = 2'b01; tick(); collision = 2'b00;
         frame_start = 1'b1; tick(); frame_start = 1'b0;
      end
      checks++; if (s_snake_length !== 8'd3 || s_score !== 10'd3) begin failures++; $display("FAIL sat_len_score got=%0d/%0d exp=3/3", s_snake_length, s_score); end
      checks++; if (snake_length !== 8'd4 || score !== 10'd3) begin failures++; $display("FAIL nosat_len_score got=%0d/%0d exp=4/3", snake_length, score); end
   endtask

   task automatic test_reset_mid_commit();
      dir_in = 4'b0001; tick(); dir_in = 4'b0000;
      collision = 2'b01; tick(); collision = 2'b00;
      frame_start = 1'b1; move_tick = 1'b1; reset = 1'b1; tick();
      frame_start = 1'b0; move_tick = 1'b0; reset = 1'b0;
      checks++; if (state !== 2'b00 || game_over !== 1'b0) begin failures++; $display("FAIL rst_commit_state got=%0h/%0h exp=0/0", state, game_over); end
      checks++; if (apple_refresh !== 1'b0 || move_en !== 1'b0) begin failures++; $display("FAIL rst_commit_pulses got=%0h/%0h exp=0/0", apple_refresh, move_en); end
      checks++; if (snake_length !== 8'd1 || score !== 10'd0 || dir_out !== 4'b1000) begin failures++; $display("FAIL rst_commit_regs got=%0d/%0d/%b exp=1/0/1000", snake_length, score, dir_out); end
      checks++; if (s_snake_length !== 8'd1 || s_score !== 10'd0) begin failures++; $display("FAIL rst_commit_sat got=%0d/%0d exp=1/0", s_snake_length, s_score); end
      press_start();
      frame_start = 1'b1; move_tick = 1'b1; tick(); frame_start = 1'b0; move_tick = 1'b0;
      checks++; if (apple_refresh !== 1'b0 || score !== 10'd0 || dir_out !== 4'b1000) begin failures++; $display("FAIL rst_pend_cleared got=%0h/%0d/%b exp=0/0/1000", apple_refresh, score, dir_out); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_apple();
      test_wall_priority();
      test_over_buttons();
      test_dir_filter();
      test_pause();
      test_back_to_back();
      test_saturation();
      test_reset_mid_commit();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
